// File: rtl/fetch_arb_pkg.sv
// rtl/fetch_arb_pkg.sv - shared sizes and FSM state type for the wavepool fetch arbiter
package fetch_arb_pkg;
   localparam int NUM_WF = 40;
   localparam int WFID_W = 6;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/rr_picker_40.sv
// rtl/rr_picker_40.sv - rotating priority encoder: first set bit at or above i_start, wrapping 39 to 0
module rr_picker_40
   import fetch_arb_pkg::*;
(
   input  logic [NUM_WF-1:0] i_vec,
   input  logic [WFID_W-1:0] i_start,
   output logic              o_found,
   output logic [WFID_W-1:0] o_idx
);

   logic [WFID_W:0] w_base;
   logic [WFID_W:0] w_pos;

   // Walk offsets from the far end down so the nearest set bit is the last one written.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_base  = (i_start >= WFID_W'(NUM_WF)) ? '0 : {1'b0, i_start};
      w_pos   = '0;
      for (int k = NUM_WF - 1; k >= 0; k--) begin
         w_pos = w_base + (WFID_W + 1)'(k);
         if (w_pos >= (WFID_W + 1)'(NUM_WF)) begin
            w_pos = w_pos - (WFID_W + 1)'(NUM_WF);
         end
         if (i_vec[w_pos[WFID_W-1:0]]) begin
            o_found = 1'b1;
            o_idx   = w_pos[WFID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fetch_rr_arbiter.sv
// rtl/fetch_rr_arbiter.sv - round-robin fetch arbiter with pending/stale tracking
// Optional perf counters: FETCH_ARB_PERF_CNT_EN
module fetch_rr_arbiter
   import fetch_arb_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_WF-1:0] i_valid_wf,
   input  logic [NUM_WF-1:0] i_q_vacant,
   input  logic [NUM_WF-1:0] i_q_reset,
   output logic              o_fetch_req,
   output logic [WFID_W-1:0] o_fetch_wfid,
   input  logic              i_fetch_ack,
   input  logic              i_ret_valid,
   input  logic [WFID_W-1:0] i_ret_wfid,
   output logic              o_ret_drop,
   output logic [31:0]       o_perf_grant_cnt,
   output logic [31:0]       o_perf_stall_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   logic [0:0]        r_state;
   logic              r_fetch_req;
   logic [WFID_W-1:0] r_fetch_wfid;
   logic [WFID_W-1:0] r_rr_ptr;
   logic [NUM_WF-1:0] r_pending;
   logic [NUM_WF-1:0] r_stale;
   logic              r_qrst_seen;

   logic [NUM_WF-1:0] w_eligible;
   logic [NUM_WF-1:0] w_pend_nxt;
   logic [NUM_WF-1:0] w_stale_nxt;
   logic              w_found;
   logic [WFID_W-1:0] w_pick;
   logic [WFID_W-1:0] w_ptr_nxt;
   logic              w_ret_hit;
   logic              w_ack_req;
   logic              w_qrst_req;

   assign w_eligible = i_valid_wf & i_q_vacant & ~r_pending & ~i_q_reset;

   rr_picker_40 u_picker (
      .i_vec   (w_eligible),
      .i_start (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_ptr_nxt  = (w_pick == WFID_W'(NUM_WF - 1)) ? '0 : w_pick + 1'b1;
   assign w_ack_req  = (r_state == ST_REQ) && i_fetch_ack;
   assign w_qrst_req = i_q_reset[r_fetch_wfid];
   // A return for a non-pending slot is a protocol error and must not touch tracking state.
   assign w_ret_hit  = i_ret_valid && (i_ret_wfid < WFID_W'(NUM_WF)) && r_pending[i_ret_wfid];
   assign o_ret_drop = w_ret_hit && (r_stale[i_ret_wfid] || i_q_reset[i_ret_wfid]);

   assign o_fetch_req  = r_fetch_req;
   assign o_fetch_wfid = r_fetch_wfid;

   always_comb begin
      w_pend_nxt  = r_pending;
      w_stale_nxt = r_stale | (i_q_reset & r_pending);
      if (w_ret_hit) begin
         w_pend_nxt[i_ret_wfid]  = 1'b0;
         w_stale_nxt[i_ret_wfid] = 1'b0;
      end
      if (w_ack_req) begin
         w_pend_nxt[r_fetch_wfid] = 1'b1;
         if (r_qrst_seen || w_qrst_req) begin
            w_stale_nxt[r_fetch_wfid] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_fetch_req  <= 1'b0;
         r_fetch_wfid <= '0;
         r_rr_ptr     <= '0;
         r_pending    <= '0;
         r_stale      <= '0;
         r_qrst_seen  <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         r_stale   <= w_stale_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_fetch_req  <= 1'b1;
                  r_fetch_wfid <= w_pick;
                  r_rr_ptr     <= w_ptr_nxt;
                  r_qrst_seen  <= 1'b0;
                  r_state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (i_fetch_ack) begin
                  r_fetch_req <= 1'b0;
                  r_qrst_seen <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_qrst_seen <= r_qrst_seen | w_qrst_req;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always @(posedge i_clk) begin
      if (!i_rst && i_ret_valid) begin
         a_ret_pending: assert (w_ret_hit);
      end
   end

`ifdef FETCH_ARB_PERF_CNT_EN
   logic [31:0] r_grant_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_grant_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_ack_req) begin
            r_grant_cnt <= r_grant_cnt + 32'd1;
         end
         if (r_fetch_req && !i_fetch_ack) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign o_perf_grant_cnt = r_grant_cnt;
   assign o_perf_stall_cnt = r_stall_cnt;
`else
   assign o_perf_grant_cnt = 32'd0;
   assign o_perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_rr_arbiter.sv
// tb/tb_fetch_rr_arbiter.sv - directed self-checking bench for fetch_rr_arbiter
module tb_fetch_rr_arbiter;
   import fetch_arb_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_WF-1:0] valid_wf = '0;
   logic [NUM_WF-1:0] q_vacant = '0;
   logic [NUM_WF-1:0] q_reset = '0;
   logic              fetch_req;
   logic [WFID_W-1:0] fetch_wfid;
   logic              fetch_ack = 1'b0;
   logic              ret_valid = 1'b0;
   logic [WFID_W-1:0] ret_wfid = '0;
   logic              ret_drop;
   logic [31:0]       perf_grant_cnt;
   logic [31:0]       perf_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [NUM_WF-1:0] ONE = 40'd1;

   fetch_rr_arbiter dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_valid_wf       (valid_wf),
      .i_q_vacant       (q_vacant),
      .i_q_reset        (q_reset),
      .o_fetch_req      (fetch_req),
      .o_fetch_wfid     (fetch_wfid),
      .i_fetch_ack      (fetch_ack),
      .i_ret_valid      (ret_valid),
      .i_ret_wfid       (ret_wfid),
      .o_ret_drop       (ret_drop),
      .o_perf_grant_cnt (perf_grant_cnt),
      .o_perf_stall_cnt (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      valid_wf  = '0;
      q_vacant  = '1;
      q_reset   = '0;
      fetch_ack = 1'b0;
      ret_valid = 1'b0;
      ret_wfid  = '0;
      tick();
      check("rst_req", {31'd0, fetch_req}, 32'd0);
      check("rst_wfid", {26'd0, fetch_wfid}, 32'd0);
      check("rst_grant_cnt", perf_grant_cnt, 32'd0);
      check("rst_stall_cnt", perf_stall_cnt, 32'd0);
      rst = 1'b0;
   endtask

   // Expect a request for exp, ack it, then return its data in the following IDLE cycle.
   task automatic do_grant(input int exp);
      check("grant_req", {31'd0, fetch_req}, 32'd1);
      check("grant_wfid", {26'd0, fetch_wfid}, 32'(exp));
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      check("ack_req_low", {31'd0, fetch_req}, 32'd0);
      ret_valid = 1'b1;
      ret_wfid  = WFID_W'(exp);
      #1;
      check("ret_drop_clean", {31'd0, ret_drop}, 32'd0);
      tick();
      ret_valid = 1'b0;
   endtask

   initial begin
      // Full sweep: every slot eligible, ack each request immediately
      do_reset();
      valid_wf = '1;
      tick();
      for (int g = 0; g <= NUM_WF; g++) begin
         do_grant(g % NUM_WF);
      end

      // Pointer wrap with only slots 5 and 38 live
      do_reset();
      valid_wf = ONE << 38;
      tick();
      valid_wf = (ONE << 5) | (ONE << 38);
      do_grant(38);
      do_grant(5);
      do_grant(38);
      do_grant(5);

      // Request held stable while ack is withheld and the slot goes invalid
      do_reset();
      valid_wf = ONE << 12;
      tick();
      valid_wf = '0;
      for (int c = 0; c < 4; c++) begin
         check("hold_req", {31'd0, fetch_req}, 32'd1);
         check("hold_wfid", {26'd0, fetch_wfid}, 32'd12);
         tick();
      end
      check("hold_req_end", {31'd0, fetch_req}, 32'd1);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      check("hold_ack_low", {31'd0, fetch_req}, 32'd0);
`ifdef FETCH_ARB_PERF_CNT_EN
      check("stall_cnt", perf_stall_cnt, 32'd4);
      check("grant_cnt", perf_grant_cnt, 32'd1);
`else
      check("stall_cnt_off", perf_stall_cnt, 32'd0);
      check("grant_cnt_off", perf_grant_cnt, 32'd0);
`endif

      // Flush of a pending slot makes its return stale
      do_reset();
      valid_wf = ONE << 7;
      tick();
      check("p7_wfid", {26'd0, fetch_wfid}, 32'd7);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      q_reset   = ONE << 7;
      tick();
      q_reset   = '0;
      check("p7_no_regrant", {31'd0, fetch_req}, 32'd0);
      ret_valid = 1'b1;
      ret_wfid  = 6'd7;
      #1;
      check("p7_drop", {31'd0, ret_drop}, 32'd1);
      tick();
      ret_valid = 1'b0;
      check("p7_idle_after_ret", {31'd0, fetch_req}, 32'd0);
      tick();
      check("p7_regrant", {31'd0, fetch_req}, 32'd1);
      check("p7_regrant_wfid", {26'd0, fetch_wfid}, 32'd7);
      // Return and flush in the same cycle: dropped, and tracking fully cleared
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      q_reset   = ONE << 7;
      ret_valid = 1'b1;
      ret_wfid  = 6'd7;
      #1;
      check("p7_same_cycle_drop", {31'd0, ret_drop}, 32'd1);
      tick();
      q_reset   = '0;
      ret_valid = 1'b0;
      tick();
      do_grant(7);

      // Flush during REQ marks the fetch stale on ack
      do_reset();
      valid_wf = ONE << 20;
      tick();
      q_reset = ONE << 20;
      tick();
      q_reset = '0;
      check("r20_req_held", {31'd0, fetch_req}, 32'd1);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      check("r20_pending_blocks", {31'd0, fetch_req}, 32'd0);
      ret_valid = 1'b1;
      ret_wfid  = 6'd20;
      #1;
      check("r20_drop", {31'd0, ret_drop}, 32'd1);
      tick();
      ret_valid = 1'b0;
      tick();
      // Flush coinciding with the ack cycle also counts
      check("r20b_wfid", {26'd0, fetch_wfid}, 32'd20);
      fetch_ack = 1'b1;
      q_reset   = ONE << 20;
      tick();
      fetch_ack = 1'b0;
      q_reset   = '0;
      ret_valid = 1'b1;
      ret_wfid  = 6'd20;
      #1;
      check("r20b_drop", {31'd0, ret_drop}, 32'd1);
      tick();
      ret_valid = 1'b0;

      // Asynchronous reset in the middle of a request
      do_reset();
      valid_wf = ONE << 3;
      tick();
      check("r3_wfid", {26'd0, fetch_wfid}, 32'd3);
      rst = 1'b1;
      #1;
      check("r3_async_drop", {31'd0, fetch_req}, 32'd0);
      check("r3_async_wfid", {26'd0, fetch_wfid}, 32'd0);
      valid_wf = (ONE << 0) | (ONE << 3);
      tick();
      rst = 1'b0;
      tick();
      do_grant(0);
      do_grant(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
